// File: rtl/hazard_pkg.sv
// Shared types and default constants for the hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int PC_REG_DEF = 15;
  localparam int REG_AW_DEF = 4;

endpackage

// File: rtl/hazard_pcw_track.sv
// Tracks PC-writing instructions through E/M/W; pcw[0]=E, pcw[1]=M, pcw[2]=W.
module hazard_pcw_track (
  input  logic clk,
  input  logic reset_n,
  input  logic pcs_d,
  input  logic condex_e,
  input  logic mem_stall,
  input  logic flush_e,
  input  logic stall_d,
  output logic pcwr_pending_f,
  output logic pcsrc_w
);

  logic [2:0] pcw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcw <= '0;
    end else if (mem_stall) begin
      // E and M are frozen; W is fed a bubble.
      pcw <= {1'b0, pcw[1:0]};
    end else begin
      pcw <= {pcw[1], pcw[0] & condex_e, pcs_d & ~flush_e & ~stall_d};
    end
  end

  assign pcwr_pending_f = pcs_d | pcw[0] | pcw[1];
  assign pcsrc_w        = pcw[2];

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Pipeline hazard controller: forwarding, load-use/memory stalls, PC-write flushes.
// Optional HAZARD_PERF_CNT_EN adds four saturating event counters on perf_cnt.
module hazard_ctrl_gen
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int PC_REG  = PC_REG_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] ra_d,
  input  logic [NUM_SRC*REG_AW-1:0] ra_e,
  input  logic [REG_AW-1:0]         wa_e,
  input  logic [REG_AW-1:0]         wa_m,
  input  logic [REG_AW-1:0]         wa_w,
  input  logic                      regwrite_e,
  input  logic                      regwrite_m,
  input  logic                      regwrite_w,
  input  logic                      memtoreg_e,
  input  logic                      pcs_d,
  input  logic                      condex_e,
  input  logic                      branch_taken_e,
  input  logic                      mem_req_m,
  input  logic                      mem_ready_m,
  output logic [NUM_SRC*2-1:0]      forward_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      flush_w,
  output logic                      pcwr_pending_f,
  output logic                      pcsrc_w
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [63:0]               perf_cnt
`endif
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);

  logic [NUM_SRC-1:0] d_hit;
  logic               ldr_stall;
  logic               mem_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] src_e;
    logic [REG_AW-1:0] src_d;
    fwd_sel_t          sel;

    assign src_e    = ra_e[i*REG_AW +: REG_AW];
    assign src_d    = ra_d[i*REG_AW +: REG_AW];
    assign d_hit[i] = (src_d == wa_e) && (src_d != PC_ADDR);

    always_comb begin
      sel = FWD_RF;
      if (regwrite_m && (src_e == wa_m) && (src_e != PC_ADDR)) begin
        sel = FWD_MEM;
      end else if (regwrite_w && (src_e == wa_w) && (src_e != PC_ADDR)) begin
        sel = FWD_WB;
      end
    end

    assign forward_e[2*i +: 2] = reset_n ? sel : FWD_RF;
  end

  assign ldr_stall = memtoreg_e & regwrite_e & (|d_hit);
  assign mem_stall = mem_req_m & ~mem_ready_m;

  // Reset forces the pipe into flush with no stalls, even mid memory stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b1;
    flush_e = 1'b1;
    flush_w = 1'b1;
    if (reset_n) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b1;
      end else begin
        stall_f = ldr_stall | pcwr_pending_f;
        stall_d = ldr_stall;
        flush_e = ldr_stall | branch_taken_e;
        flush_d = pcwr_pending_f | pcsrc_w | branch_taken_e;
        flush_w = 1'b0;
      end
    end
  end

  hazard_pcw_track u_pcw_track (
    .clk            (clk),
    .reset_n        (reset_n),
    .pcs_d          (pcs_d),
    .condex_e       (condex_e),
    .mem_stall      (mem_stall),
    .flush_e        (flush_e),
    .stall_d        (stall_d),
    .pcwr_pending_f (pcwr_pending_f),
    .pcsrc_w        (pcsrc_w)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0][15:0] cnt;
  logic [3:0]       cnt_ev;

  assign cnt_ev = {pcsrc_w, branch_taken_e & ~mem_stall, mem_stall, ldr_stall & ~mem_stall};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_ev[i] && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign perf_cnt = cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Self-checking bench for hazard_ctrl_gen: directed scenarios plus a randomized model comparison.
module tb_hazard_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] ra_d, ra_e;
  logic [3:0]  wa_e, wa_m, wa_w;
  logic        regwrite_e, regwrite_m, regwrite_w, memtoreg_e;
  logic        pcs_d, condex_e, branch_taken_e, mem_req_m, mem_ready_m;
  logic [5:0]  forward_e;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w, pcwr_pending_f, pcsrc_w;
`ifdef HAZARD_PERF_CNT_EN
  logic [63:0] perf_cnt;
`endif

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_gen dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ra_d           (ra_d),
    .ra_e           (ra_e),
    .wa_e           (wa_e),
    .wa_m           (wa_m),
    .wa_w           (wa_w),
    .regwrite_e     (regwrite_e),
    .regwrite_m     (regwrite_m),
    .regwrite_w     (regwrite_w),
    .memtoreg_e     (memtoreg_e),
    .pcs_d          (pcs_d),
    .condex_e       (condex_e),
    .branch_taken_e (branch_taken_e),
    .mem_req_m      (mem_req_m),
    .mem_ready_m    (mem_ready_m),
    .forward_e      (forward_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_w        (flush_w),
    .pcwr_pending_f (pcwr_pending_f),
    .pcsrc_w        (pcsrc_w)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_cnt       (perf_cnt)
`endif
  );

  task automatic idle();
    ra_d = '0; ra_e = '0; wa_e = '0; wa_m = '0; wa_w = '0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0; memtoreg_e = 0;
    pcs_d = 0; condex_e = 0; branch_taken_e = 0; mem_req_m = 0; mem_ready_m = 1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  function automatic logic [3:0] rnd_addr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_reset();
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    mem_req_m = 1; mem_ready_m = 0; branch_taken_e = 1;
    regwrite_m = 1; ra_e = 12'h003; wa_m = 4'd3;
    #1;
    tests_run++;
    if ({stall_f, stall_d, stall_e, stall_m} !== 4'b0000) begin
      fails++; $display("FAIL reset_stalls: got %b want 0000", {stall_f, stall_d, stall_e, stall_m});
    end
    tests_run++;
    if ({flush_d, flush_e, flush_w} !== 3'b111) begin
      fails++; $display("FAIL reset_flushes: got %b want 111", {flush_d, flush_e, flush_w});
    end
    tests_run++;
    if (forward_e !== 6'b0) begin
      fails++; $display("FAIL reset_forward: got %b want 000000", forward_e);
    end
    idle();
    @(posedge clk); #1 reset_n = 1;
    #1;
    tests_run++;
    if ({stall_f, stall_d, flush_d, flush_e, flush_w, pcwr_pending_f, pcsrc_w} !== 7'b0) begin
      fails++; $display("FAIL reset_release_idle: got %b want 0000000",
                        {stall_f, stall_d, flush_d, flush_e, flush_w, pcwr_pending_f, pcsrc_w});
    end
  endtask

  task automatic test_forward();
    do_reset();
    @(posedge clk); #1;
    ra_e = {4'd0, 4'd0, 4'd3}; wa_m = 4'd3; regwrite_m = 1; wa_w = 4'd3; regwrite_w = 1;
    #1;
    tests_run++;
    if (forward_e !== 6'b000010) begin
      fails++; $display("FAIL fwd_mem_priority: got %b want 000010", forward_e);
    end
    regwrite_m = 0;
    #1;
    tests_run++;
    if (forward_e !== 6'b000001) begin
      fails++; $display("FAIL fwd_wb: got %b want 000001", forward_e);
    end
    ra_e = {4'd0, 4'd0, 4'd15}; wa_m = 4'd15; wa_w = 4'd15; regwrite_m = 1;
    #1;
    tests_run++;
    if (forward_e !== 6'b000000) begin
      fails++; $display("FAIL fwd_pc_reg: got %b want 000000", forward_e);
    end
    ra_e = {4'd7, 4'd9, 4'd1}; wa_m = 4'd9; wa_w = 4'd7;
    #1;
    tests_run++;
    if (forward_e !== 6'b011000) begin
      fails++; $display("FAIL fwd_mixed_ops: got %b want 011000", forward_e);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(posedge clk); #1;
    memtoreg_e = 1; regwrite_e = 1; wa_e = 4'd5; ra_d = {4'd5, 4'd0, 4'd0};
    #1;
    tests_run++;
    if ({stall_f, stall_d, flush_e, flush_d, stall_e} !== 5'b11100) begin
      fails++; $display("FAIL load_use_hit: got %b want 11100", {stall_f, stall_d, flush_e, flush_d, stall_e});
    end
    @(posedge clk); #1;
    memtoreg_e = 0;
    #1;
    tests_run++;
    if ({stall_f, stall_d, flush_e, flush_d} !== 4'b0000) begin
      fails++; $display("FAIL load_use_release: got %b want 0000", {stall_f, stall_d, flush_e, flush_d});
    end
    memtoreg_e = 1; wa_e = 4'd15; ra_d = {4'd0, 4'd0, 4'd15};
    #1;
    tests_run++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      fails++; $display("FAIL load_use_pc_reg: got %b want 000", {stall_f, stall_d, flush_e});
    end
  endtask

  task automatic test_pc_write(input logic cx);
    int last_pend;
    last_pend = cx ? 3 : 2;
    do_reset();
    condex_e = cx;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      pcs_d = (c == 1);
      #1;
      tests_run++;
      if ({pcwr_pending_f, pcsrc_w, flush_d} !==
          {(c <= last_pend), (cx && c == 4), (c <= last_pend) || (cx && c == 4)}) begin
        fails++;
        $display("FAIL pc_write condex=%0d cycle %0d: got pend/src/fd=%b want %b", cx, c,
                 {pcwr_pending_f, pcsrc_w, flush_d},
                 {(c <= last_pend), (cx && c == 4), (c <= last_pend) || (cx && c == 4)});
      end
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_req_m = 1; mem_ready_m = 0; branch_taken_e = 1;
      memtoreg_e = 1; regwrite_e = 1; wa_e = 4'd2; ra_d = 12'h020;
      #1;
      tests_run++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1111100) begin
        fails++; $display("FAIL mem_stall cycle %0d: got %b want 1111100", c,
                          {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
      end
    end
    @(posedge clk); #1;
    mem_ready_m = 1;
    #1;
    tests_run++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1100011) begin
      fails++; $display("FAIL mem_stall_release: got %b want 1100011",
                        {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    condex_e = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1 pcs_d = 1;
    end
    @(posedge clk); #1;
    pcs_d = 0; mem_req_m = 1; mem_ready_m = 0;
    #1;
    tests_run++;
    if ({pcwr_pending_f, stall_f, stall_m} !== 3'b111) begin
      fails++; $display("FAIL mid_stall_setup: got %b want 111", {pcwr_pending_f, stall_f, stall_m});
    end
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    tests_run++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} !== 7'b0000111) begin
      fails++; $display("FAIL mid_stall_reset: got %b want 0000111",
                        {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w});
    end
    @(posedge clk); #1;
    idle(); condex_e = 1; reset_n = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if ({pcwr_pending_f, pcsrc_w} !== 2'b00) begin
        fails++; $display("FAIL mid_stall_pcw_clear cycle %0d: got %b want 00", c, {pcwr_pending_f, pcsrc_w});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit pc_in_e, pc_in_m, pc_in_w;
    bit ldr, ms, pend;
    logic [1:0] fsel;
    logic [3:0] s;
    logic [14:0] exp_v, got_v;
    logic [5:0] fexp;
    logic [6:0] ctl;
    int bad;
    do_reset();
    pc_in_e = 0; pc_in_m = 0; pc_in_w = 0;
    bad = 0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      ra_d = {rnd_addr(), rnd_addr(), rnd_addr()};
      ra_e = {rnd_addr(), rnd_addr(), rnd_addr()};
      wa_e = rnd_addr(); wa_m = rnd_addr(); wa_w = rnd_addr();
      regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1)); memtoreg_e = 1'($urandom_range(0, 1));
      pcs_d = ($urandom_range(0, 3) == 0); condex_e = 1'($urandom_range(0, 1));
      branch_taken_e = ($urandom_range(0, 5) == 0);
      mem_req_m = 1'($urandom_range(0, 1)); mem_ready_m = ($urandom_range(0, 2) != 0);
      #1;
      ldr = 0;
      fexp = '0;
      for (int i = 0; i < 3; i++) begin
        s = ra_d[i*4 +: 4];
        if (memtoreg_e && regwrite_e && s == wa_e && s != 4'd15) ldr = 1;
        s = ra_e[i*4 +: 4];
        fsel = 2'b00;
        if (s != 4'd15) begin
          if (regwrite_m && s == wa_m) fsel = 2'b10;
          else if (regwrite_w && s == wa_w) fsel = 2'b01;
        end
        fexp[i*2 +: 2] = fsel;
      end
      ms = mem_req_m && !mem_ready_m;
      pend = pcs_d || pc_in_e || pc_in_m;
      // ctl = {sf, sd, se, sm, fd, fe, fw}
      if (ms) ctl = 7'b1111001;
      else ctl = {ldr || pend, ldr, 2'b00, pend || pc_in_w || branch_taken_e, ldr || branch_taken_e, 1'b0};
      exp_v = {ctl, pend, pc_in_w, fexp};
      got_v = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, pcwr_pending_f, pcsrc_w, forward_e};
      tests_run++;
      if (got_v !== exp_v) begin
        fails++;
        if (bad < 10) $display("FAIL random cycle %0d: got %b want %b", n, got_v, exp_v);
        bad++;
      end
      if (ms) begin
        pc_in_w = 0;
      end else begin
        pc_in_w = pc_in_m;
        pc_in_m = pc_in_e && condex_e;
        pc_in_e = pcs_d && !ctl[1] && !ctl[5];
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    #1;
    tests_run++;
    if (perf_cnt !== 64'd0) begin
      fails++; $display("FAIL perf_reset: got %h want 0", perf_cnt);
    end
    @(posedge clk); #1;
    memtoreg_e = 1; regwrite_e = 1; wa_e = 4'd4; ra_d = 12'h004;
    repeat (3) @(posedge clk);
    #1 idle(); branch_taken_e = 1;
    repeat (2) @(posedge clk);
    #1 idle(); mem_req_m = 1; mem_ready_m = 0;
    repeat (65540) @(posedge clk);
    #1 idle();
    #1;
    tests_run++;
    if (perf_cnt !== {16'd0, 16'd2, 16'hFFFF, 16'd3}) begin
      fails++; $display("FAIL perf_saturate: got %h want %h", perf_cnt, {16'd0, 16'd2, 16'hFFFF, 16'd3});
    end
  endtask
`endif

  initial begin
    idle();
    reset_n = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_pc_write(1'b1);
    test_pc_write(1'b0);
    test_mem_stall();
    test_reset_mid_stall();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
